// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_detector
// Description : Serial pattern detector. Compares the newest WIDTH accepted
//               bits against PATTERN (MSB received first), with Mealy and
//               registered match outputs and a saturating match counter.
//               Overlapping or non-overlapping detection is selectable.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_detector #(
  parameter int unsigned WIDTH   = 3,
  parameter logic [31:0] PATTERN = 32'b010,
  parameter bit          OVERLAP = 1'b1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             x,
  input  logic             clear,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int unsigned HIST_W = WIDTH - 1;
  localparam int unsigned FILL_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  PAT       = PATTERN[WIDTH-1:0];

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("seq_pattern_detector: WIDTH must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_pattern_detector: CNT_W must be in 1..32");
  end
  if ((PATTERN >> WIDTH) != 32'd0) begin : g_bad_pattern
    $error("seq_pattern_detector: PATTERN is wider than WIDTH");
  end

  logic [HIST_W-1:0] hist;
  logic [HIST_W-1:0] hist_next;
  logic [FILL_W-1:0] fill;
  logic              full;
  logic              window_hit;

  // With a single history bit there is nothing to shift, only replace.
  if (HIST_W == 1) begin : g_hist_single
    assign hist_next = x;
  end else begin : g_hist_shift
    assign hist_next = {hist[HIST_W-2:0], x};
  end

  // The window only counts once WIDTH real bits have been collected, so
  // reset-value zeros can never produce a match.
  assign full       = (fill == FILL_FULL);
  assign window_hit = ({hist, x} == PAT);
  assign y          = en & ~clear & full & window_hit;
  assign count_sat  = &match_count;

  // History shift register and fill level; fill acts as the S0..S(WIDTH-1)
  // state and stops at full, after which the shift register does the work.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= hist_next;
      if (y) begin
        // Non-overlapping mode restarts collection after every match.
        if (!OVERLAP) begin
          fill <= '0;
        end
      end else if (!full) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  // Registered match pulse and saturating match counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      y_q         <= 1'b0;
      match_count <= '0;
    end else if (clear) begin
      y_q         <= 1'b0;
      match_count <= '0;
    end else begin
      y_q <= y;
      if (y && !count_sat) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_pattern_detector
// Description : Self-checking bench for seq_pattern_detector. Four instances
//               cover the default, non-overlapping, 8-bit and saturating
//               counter configurations; one is exercised at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_detector;

  typedef struct {
    logic en;
    logic x;
    logic clear;
    logic y;
  } vec_t;

  typedef struct {
    logic        yq;
    logic [31:0] cnt;
    logic        sat;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] en_v  = '0;
  logic [3:0] x_v   = '0;
  logic [3:0] clr_v = '0;
  logic [3:0] y_v;
  logic [3:0] yq_v;
  logic [3:0] sat_v;
  logic [7:0] mc0, mc1, mc2;
  logic [1:0] mc3;

  logic [1:0]  sel = 2'd0;
  logic        y_m, yq_m, sat_m;
  logic [31:0] cnt_m;
  logic [31:0] cnt_max;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_cnt = 0;
  exp_t sb[$];
  vec_t tbl[$];

  always #5 clock = ~clock;

  seq_pattern_detector u_def (
    .clock(clock), .reset_n(reset_n), .en(en_v[0]), .x(x_v[0]), .clear(clr_v[0]),
    .y(y_v[0]), .y_q(yq_v[0]), .match_count(mc0), .count_sat(sat_v[0]));

  seq_pattern_detector #(.OVERLAP(1'b0)) u_novl (
    .clock(clock), .reset_n(reset_n), .en(en_v[1]), .x(x_v[1]), .clear(clr_v[1]),
    .y(y_v[1]), .y_q(yq_v[1]), .match_count(mc1), .count_sat(sat_v[1]));

  seq_pattern_detector #(.WIDTH(8), .PATTERN(32'hA5)) u_w8 (
    .clock(clock), .reset_n(reset_n), .en(en_v[2]), .x(x_v[2]), .clear(clr_v[2]),
    .y(y_v[2]), .y_q(yq_v[2]), .match_count(mc2), .count_sat(sat_v[2]));

  seq_pattern_detector #(.WIDTH(2), .PATTERN(32'b11), .CNT_W(2), .OVERLAP(1'b1)) u_sat (
    .clock(clock), .reset_n(reset_n), .en(en_v[3]), .x(x_v[3]), .clear(clr_v[3]),
    .y(y_v[3]), .y_q(yq_v[3]), .match_count(mc3), .count_sat(sat_v[3]));

  // Route the selected instance to common observation signals.
  always_comb begin
    y_m     = y_v[sel];
    yq_m    = yq_v[sel];
    sat_m   = sat_v[sel];
    cnt_m   = 32'(mc0);
    cnt_max = 32'd255;
    case (sel)
      2'd1:    cnt_m = 32'(mc1);
      2'd2:    cnt_m = 32'(mc2);
      2'd3: begin
        cnt_m   = 32'(mc3);
        cnt_max = 32'd3;
      end
      default: cnt_m = 32'(mc0);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d, t=%0t): got %0h, expected %0h", name, sel, $time, act, exp);
    end
  endtask

  // Called at posedge+1: drive one cycle, check y mid-cycle, then check the
  // registered results popped from the scoreboard after the edge.
  task automatic step(input logic e, input logic xi, input logic c, input logic exp_y);
    exp_t ex;
    en_v[sel]  = e;
    x_v[sel]   = xi;
    clr_v[sel] = c;
    if (c) model_cnt = 0;
    else if (exp_y && model_cnt < cnt_max) model_cnt = model_cnt + 1;
    @(negedge clock);
    chk("y", 32'(y_m), 32'(exp_y));
    sb.push_back('{yq: exp_y, cnt: model_cnt, sat: (model_cnt == cnt_max)});
    @(posedge clock);
    #1;
    ex = sb.pop_front();
    chk("y_q", 32'(yq_m), 32'(ex.yq));
    chk("match_count", cnt_m, ex.cnt);
    chk("count_sat", 32'(sat_m), 32'(ex.sat));
  endtask

  task automatic run_table();
    foreach (tbl[i]) step(tbl[i].en, tbl[i].x, tbl[i].clear, tbl[i].y);
    tbl.delete();
    en_v[sel] = 1'b0; clr_v[sel] = 1'b0;
  endtask

  task automatic add(input logic e, input logic xi, input logic c, input logic yy);
    tbl.push_back('{en: e, x: xi, clear: c, y: yy});
  endtask

  task automatic do_reset(input logic [1:0] s);
    en_v = '0; x_v = '0; clr_v = '0;
    sel = s;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_cnt = 0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Default configuration: overlapping "010".
    do_reset(2'd0);
    @(negedge clock);
    chk("reset_y", 32'(y_m), 32'd0);
    chk("reset_y_q", 32'(yq_m), 32'd0);
    chk("reset_count", cnt_m, 32'd0);
    chk("reset_sat", 32'(sat_m), 32'd0);
    @(posedge clock); #1;
    add(1,0,0,0); add(1,1,0,0); add(1,0,0,1); add(1,1,0,0); add(1,0,0,1);
    run_table();
    chk("ovl_final_count", cnt_m, 32'd2);

    // Non-overlapping: after the restart the next window ends on bit 7.
    do_reset(2'd1);
    add(1,0,0,0); add(1,1,0,0); add(1,0,0,1); add(1,1,0,0); add(1,0,0,0);
    add(1,1,0,0); add(1,0,0,1); add(1,1,0,0); add(1,0,0,0);
    run_table();
    chk("novl_final_count", cnt_m, 32'd2);

    // WIDTH=8, 0xA5 with idle cycles (x toggled) between accepted bits.
    do_reset(2'd2);
    begin
      logic [7:0] pat8;
      pat8 = 8'hA5;
      for (int i = 7; i >= 0; i--) begin
        add(1, pat8[i], 0, (i == 0));
        add(0, ~pat8[i], 0, 0);
      end
    end
    run_table();
    chk("w8_final_count", cnt_m, 32'd1);

    // 2-bit counter saturation on an all-ones stream, then clear.
    do_reset(2'd3);
    for (int i = 0; i < 6; i++) add(1, 1, 0, (i != 0));
    add(0,0,1,0); add(1,1,0,0); add(1,1,0,1);
    run_table();

    // Clear together with the completing bit wins; next "010" counts.
    do_reset(2'd0);
    add(1,0,0,0); add(1,1,0,0); add(1,0,1,0);
    add(1,0,0,0); add(1,1,0,0); add(1,0,0,1);
    run_table();
    chk("clear_final_count", cnt_m, 32'd1);

    // Asynchronous reset in the middle of a pending match.
    do_reset(2'd0);
    add(1,0,0,0); add(1,1,0,0); add(1,0,0,1); add(1,1,0,0);
    run_table();
    en_v[0] = 1'b1; x_v[0] = 1'b0;
    #2;
    chk("pre_reset_y", 32'(y_m), 32'd1);
    chk("pre_reset_count", cnt_m, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_y", 32'(y_m), 32'd0);
    chk("async_reset_y_q", 32'(yq_m), 32'd0);
    chk("async_reset_count", cnt_m, 32'd0);
    chk("async_reset_sat", 32'(sat_m), 32'd0);
    en_v[0] = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_cnt = 0;
    add(1,0,0,0); add(1,0,0,0); add(1,1,0,0); add(1,0,0,1);
    run_table();
    chk("post_reset_count", cnt_m, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
